// File: rtl/cp0_timer_pkg.sv
// Shared constants for the CP0 timer: register offsets, CTRL field layout,
// mode encodings and FSM state encoding.
package timer_pkg;

   localparam logic [1:0] TC_CTRL   = 2'd0;
   localparam logic [1:0] TC_PRESET = 2'd1;
   localparam logic [1:0] TC_COUNT  = 2'd2;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

   localparam logic [1:0] MODE_ONESHOT  = 2'b00;
   localparam logic [1:0] MODE_PERIODIC = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_CNT  = 2'b10,
      ST_INT  = 2'b11
   } state_e;

   // Modes 10/11 fall back to one-shot, so only 01 reloads.
   function automatic logic is_periodic(input logic [3:0] ctrl);
      return (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_PERIODIC);
   endfunction

endpackage

// File: rtl/cp0_timer_if.sv
// Bus window between the system bridge (master) and the timer (slave).
interface cp0_timer_if #(parameter int DATA_W = 32);

   logic [1:0]        addr;
   logic              we;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              irq;

   modport master (output addr, output we, output wdata, input rdata, input irq);
   modport slave  (input addr, input we, input wdata, output rdata, output irq);

endinterface

// File: rtl/cp0_timer.sv
// Programmable down-counter timer behind a 3-word register window; drives
// CP0 HWInt[0] in one-shot or auto-reload periodic mode.
module cp0_timer
   import timer_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic       clk,
   input  logic       reset,
   cp0_timer_if.slave bus
);

   localparam logic [DATA_W-1:0] CNT_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] CNT_ZERO = {DATA_W{1'b0}};

   logic [3:0]        ctrl_q,     ctrl_d;
   logic [DATA_W-1:0] preset_q,   preset_d;
   logic [DATA_W-1:0] count_q,    count_d;
   logic              irq_flag_q, irq_flag_d;
   state_e            state_q,    state_d;

   logic wr_ctrl_s;
   logic wr_preset_s;
   logic en_s;

   assign wr_ctrl_s   = bus.we && (bus.addr == TC_CTRL);
   assign wr_preset_s = bus.we && (bus.addr == TC_PRESET);
   assign en_s        = ctrl_q[CTRL_EN];

   // Next-state logic: counter FSM first, then bus writes override it.
   always_comb begin
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      irq_flag_d = irq_flag_q;
      state_d    = state_q;

      case (state_q)
         ST_IDLE: begin
            if (en_s) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (en_s) begin
               count_d = preset_q;
               state_d = ST_CNT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CNT: begin
            if (!en_s) begin
               state_d = ST_IDLE;
            end else if (count_q > CNT_ONE) begin
               count_d = count_q - CNT_ONE;
            end else begin
               // Covers COUNT==0 too, so the counter never wraps.
               count_d    = CNT_ZERO;
               irq_flag_d = 1'b1;
               state_d    = ST_INT;
            end
         end
         ST_INT: begin
            if (is_periodic(ctrl_q)) begin
               irq_flag_d = 1'b0;
               state_d    = ST_LOAD;
            end else begin
               ctrl_d[CTRL_EN] = 1'b0;
               state_d         = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A software write acknowledges the interrupt and beats any FSM update.
      if (wr_ctrl_s) begin
         ctrl_d     = bus.wdata[3:0];
         irq_flag_d = 1'b0;
      end else if (wr_preset_s) begin
         preset_d   = bus.wdata;
         irq_flag_d = 1'b0;
      end else begin
         irq_flag_d = irq_flag_d;
      end
   end

   // State and register file flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q     <= 4'd0;
         preset_q   <= CNT_ZERO;
         count_q    <= CNT_ZERO;
         irq_flag_q <= 1'b0;
         state_q    <= ST_IDLE;
      end else begin
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_flag_q <= irq_flag_d;
         state_q    <= state_d;
      end
   end

   // Read mux, combinational from addr.
   always_comb begin
      bus.rdata = CNT_ZERO;
      case (bus.addr)
         TC_CTRL:   bus.rdata = {{(DATA_W-4){1'b0}}, ctrl_q};
         TC_PRESET: bus.rdata = preset_q;
         TC_COUNT:  bus.rdata = count_q;
         default:   bus.rdata = CNT_ZERO;
      endcase
   end

   assign bus.irq = irq_flag_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_cp0_timer.sv
// Directed self-checking bench for cp0_timer with hand-computed expectations.
module tb_cp0_timer;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   cp0_timer_if #(.DATA_W(32)) bus ();

   cp0_timer #(.DATA_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
      bus.addr = a;
      bus.we   = 1'b0;
      #1;
      chk(tag, bus.rdata, exp);
   endtask

   task automatic chk_irq(input logic exp, input string tag);
      chk(tag, {31'd0, bus.irq}, {31'd0, exp});
   endtask

   // Advance n rising edges and settle 1ns after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Write is sampled at the next rising edge; returns 1ns after it.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.addr  = a;
      bus.wdata = d;
      bus.we    = 1'b1;
      @(posedge clk);
      #1;
      bus.we    = 1'b0;
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      reset     = 1'b1;
      bus.addr  = 2'd0;
      bus.we    = 1'b0;
      bus.wdata = 32'd0;
      tick(2);
      reset = 1'b0;

      // Reset state
      rd(2'd0, 32'd0, "rst_ctrl");
      rd(2'd1, 32'd0, "rst_preset");
      rd(2'd2, 32'd0, "rst_count");
      rd(2'd3, 32'd0, "rst_rsvd");
      chk_irq(1'b0, "rst_irq");
      wr(2'd2, 32'h0000_1234);
      wr(2'd3, 32'h0000_5678);
      rd(2'd2, 32'd0, "count_wr_ignored");
      rd(2'd3, 32'd0, "rsvd_wr_ignored");

      // One-shot, PRESET=5, CTRL write at E0
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h9);
      tick(1);
      rd(2'd2, 32'd0, "os_load_cycle");
      for (int k = 2; k <= 7; k++) begin
         tick(1);
         rd(2'd2, 32'(7 - k), "os_count");
         chk_irq(k == 7, "os_irq");
      end
      tick(1);
      chk_irq(1'b1, "os_irq_held");
      rd(2'd0, 32'h8, "os_en_cleared");
      tick(3);
      chk_irq(1'b1, "os_irq_sticky");
      rd(2'd2, 32'd0, "os_count_stays0");
      wr(2'd0, 32'h8);
      chk_irq(1'b0, "os_irq_ack");

      // Periodic, PRESET=3: pulse every 5 cycles
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);
      for (int k = 1; k <= 21; k++) begin
         tick(1);
         rd(2'd2, (k < 2) ? 32'd0 :
                  (((k - 2) % 5) < 3) ? 32'(3 - ((k - 2) % 5)) : 32'd0, "per_count");
         chk_irq((k >= 5) && (((k - 5) % 5) == 0), "per_irq");
      end
      wr(2'd0, 32'h0);

      // Masked: flag sets but irq stays low
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h1);
      for (int k = 1; k <= 6; k++) begin
         tick(1);
         chk_irq(1'b0, "mask_irq");
         if (k == 2) rd(2'd2, 32'd2, "mask_count2");
         if (k == 4) rd(2'd2, 32'd0, "mask_count0");
      end
      rd(2'd0, 32'h0, "mask_en_cleared");
      wr(2'd0, 32'h8);
      chk_irq(1'b0, "mask_unmask_irq");
      tick(1);
      chk_irq(1'b0, "mask_unmask_irq2");

      // Mid-operation PRESET change and disable
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h9);
      tick(2);
      rd(2'd2, 32'd10, "mid_count10");
      tick(4);
      rd(2'd2, 32'd6, "mid_count6");
      wr(2'd1, 32'd2);
      rd(2'd2, 32'd5, "mid_preset_no_effect");
      wr(2'd0, 32'h8);
      rd(2'd2, 32'd4, "mid_count4");
      tick(3);
      rd(2'd2, 32'd4, "mid_hold4");
      rd(2'd0, 32'h8, "mid_ctrl");
      rd(2'd1, 32'd2, "mid_preset");
      chk_irq(1'b0, "mid_irq");

      // Re-enable restarts from PRESET
      wr(2'd0, 32'h9);
      tick(1);
      rd(2'd2, 32'd4, "re_load_cycle");
      tick(1);
      rd(2'd2, 32'd2, "re_reload2");
      tick(1);
      rd(2'd2, 32'd1, "re_count1");
      chk_irq(1'b0, "re_irq_low");
      tick(1);
      rd(2'd2, 32'd0, "re_count0");
      chk_irq(1'b1, "re_irq_high");
      tick(1);
      chk_irq(1'b1, "re_irq_held");
      wr(2'd1, 32'd6);
      chk_irq(1'b0, "re_preset_wr_ack");

      // Reset mid-count at COUNT=3
      wr(2'd0, 32'h9);
      tick(2);
      rd(2'd2, 32'd6, "rm_count6");
      tick(3);
      rd(2'd2, 32'd3, "rm_count3");
      reset = 1'b1;
      tick(1);
      rd(2'd0, 32'd0, "rm_ctrl");
      rd(2'd1, 32'd0, "rm_preset");
      rd(2'd2, 32'd0, "rm_count");
      chk_irq(1'b0, "rm_irq");
      reset = 1'b0;
      tick(2);
      rd(2'd2, 32'd0, "rm_idle_count");

      // Collision: CTRL write in the INT cycle keeps EN and restarts
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h9);
      tick(3);
      rd(2'd2, 32'd1, "col_count1");
      chk_irq(1'b0, "col_irq_pre");
      tick(1);
      chk_irq(1'b1, "col_irq_set");
      wr(2'd0, 32'h9);
      chk_irq(1'b0, "col_irq_cleared");
      rd(2'd0, 32'h9, "col_en_kept");
      tick(1);
      rd(2'd2, 32'd0, "col_load_cycle");
      tick(1);
      rd(2'd2, 32'd2, "col_reload2");
      tick(1);
      chk_irq(1'b0, "col_irq_low");
      tick(1);
      chk_irq(1'b1, "col_irq_again");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cp0_timer.md
Name: cp0_timer

Overview:
- Memory-mapped programmable down-counter timer that sits upstream of CP0.
- Its irq output drives CP0 HWInt[0] through the system bridge.
- Software programs it with sw/lw through a 3-word register window; the bridge has already decoded the base address.
- Supports one-shot (mode 0) and auto-reload periodic (mode 1) interrupt generation.

Parameters:
- DATA_W, 32, width of the PRESET/COUNT registers and the data bus.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- addr  input  2  word offset within the window (0=CTRL, 1=PRESET, 2=COUNT, 3=reserved)
- we  input  1  write strobe from the bridge, single cycle
- wdata  input  DATA_W  write data
- rdata  output  DATA_W  read data, combinational from addr
- irq  output  1  interrupt request to CP0 HWInt[0]

Behaviour:
- Reset: reset and clock are as already decided (reset reset, synchronous, active-high; clock clk).
  - CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0.
  - Resulting outputs: irq=0; rdata reflects the zeroed registers.
- CTRL[3:0] bits: [0]=EN, [2:1]=MODE (00 one-shot, 01 periodic; 10/11 behave as 00), [3]=IM. Bits 31:4 read as 0.
- Writes are registered and visible the cycle after the we edge:
  - addr0 loads CTRL from wdata[3:0].
  - addr1 loads PRESET.
  - addr2 and addr3 writes are ignored.
- rdata mux: addr0={28'b0,CTRL}, addr1=PRESET, addr2=COUNT, addr3=0.
- irq = irq_flag & CTRL.IM (combinational).
- FSM states IDLE, LOAD, CNT, INT:
  - IDLE: EN=1 -> LOAD; otherwise stay.
  - LOAD: COUNT<=PRESET, -> CNT. If EN=0 -> IDLE and COUNT is unchanged.
  - CNT, EN=0: -> IDLE, COUNT holds its value.
  - CNT, EN=1, COUNT>1: COUNT<=COUNT-1.
  - CNT, EN=1, COUNT<=1: COUNT<=0, irq_flag<=1, -> INT.
  - INT, mode 0: EN<=0, -> IDLE, irq_flag stays 1.
  - INT, mode 1: irq_flag<=0 (one-cycle pulse), -> LOAD.
- Timing:
  - With PRESET=P>=1 and the CTRL write at edge E0, irq_flag is visible after edge E0+P+2.
  - Mode-1 period is P+2 cycles.
- irq_flag clear: a bus write to CTRL or PRESET clears irq_flag. When the clear coincides with a set, the write wins.
- Simultaneous events: a bus write to CTRL in the INT cycle overrides the FSM's EN<=0.
- PRESET write mid-count: does not alter COUNT; takes effect at the next LOAD.
- Re-enable after a stop in CNT: a CTRL write with EN=1 goes IDLE->LOAD, so COUNT restarts from PRESET (no resume).
- PRESET=0: LOAD->CNT with COUNT=0, then INT on the next edge (same as P=1 timing).
- Reset mid-count returns everything to reset values on the next edge; irq drops immediately after that edge.
- No arithmetic underflow: COUNT never decrements below 0.

Decomposition:
- Package timer_pkg holds:
  - register offsets (TC_CTRL=0, TC_PRESET=1, TC_COUNT=2)
  - CTRL bit indices (EN=0, MODE=2:1, IM=3)
  - mode encodings (MODE_ONESHOT=2'b00, MODE_PERIODIC=2'b01)
  - 2-bit FSM state encoding (IDLE, LOAD, CNT, INT)
- Single module, no sub-module. Register file, FSM and read mux are one flat block.

Test Plan:
- Reset then read all addrs -> rdata 0,0,0,0 and irq=0. Write addr2=0x1234 -> COUNT still reads 0.
- One-shot: PRESET=5, then CTRL=0x9 (EN|IM) at edge E0:
  - COUNT reads 5 after E0+2, 4 after E0+3, ... 0 after E0+7.
  - irq=1 from E0+7 and stays high; CTRL reads 0x8 after E0+8.
  - Write CTRL=0x8 -> irq=0 next cycle.
- Periodic: PRESET=3, CTRL=0xB -> irq one-cycle pulses every 5 cycles over 4 periods, with COUNT reloading to 3 after each pulse.
- Mask: PRESET=2, CTRL=0x1 -> irq stays 0 while irq_flag sets. Then write CTRL=0x8 -> irq stays 0, because the CTRL write clears irq_flag.
- Mid-operation:
  - PRESET=10, enable; at COUNT=6 write PRESET=2 -> counts through to 0 unaffected.
  - Disable at COUNT=4 -> COUNT holds 4.
  - Re-enable -> reloads to 2.
  - Assert reset at COUNT=3 -> all registers 0 and irq=0 after the next edge.
- Collision: in the INT cycle of a one-shot, write CTRL=0x9 -> EN remains 1, irq_flag cleared, FSM goes IDLE then LOAD and restarts.
